// File: rtl/iq_envelope_detector_if.sv
// I/Q sample streams in, envelope magnitude and FIFO status out.
interface iq_envelope_detector_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] real_in;
    logic              real_valid;
    logic [DATA_W-1:0] hilbert_in;
    logic              hilbert_valid;
    logic              flush;
    logic [DATA_W-1:0] mag_out;
    logic              mag_valid;
    logic [1:0]        overflow;
    logic [LW-1:0]     i_level;
    logic [LW-1:0]     q_level;

    modport master (
        output real_in, real_valid, hilbert_in, hilbert_valid, flush,
        input  mag_out, mag_valid, overflow, i_level, q_level
    );

    modport slave (
        input  real_in, real_valid, hilbert_in, hilbert_valid, flush,
        output mag_out, mag_valid, overflow, i_level, q_level
    );
endinterface

// File: rtl/iq_envelope_detector.sv
// Pairs I/Q samples through skew FIFOs, reduces each pair to a saturated magnitude
// (L1 or alpha-max-beta-min) and optionally decimates the result stream.
module iq_envelope_detector #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAG_MODE   = 0,
    parameter int unsigned DECIM      = 1
) (
    input logic                   clk,
    input logic                   rst,
    iq_envelope_detector_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] mem_q    [2][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q [2];
    logic [AW-1:0]     rd_ptr_q [2];
    logic [LW-1:0]     cnt_q    [2];
    logic [DATA_W-1:0] wr_data  [2];
    logic [1:0]        wr_req, accept, drop, nonempty;
    logic [1:0]        ovf_q;
    logic              pop;

    logic              s1_vld_q, s2_vld_q, mag_valid_q;
    logic [DATA_W-1:0] s1_i_q, s1_q_q, s1_max, s1_min, sat, mag_q;
    logic [DATA_W:0]   comb, s2_q;
    logic [CW-1:0]     dec_cnt_q;
    logic              emit;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        // Most-negative input becomes 2^(DATA_W-1) as an unsigned value, no wrap.
        return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
    endfunction

    always_comb begin
        wr_req     = {bus.hilbert_valid, bus.real_valid};
        wr_data[0] = bus.real_in;
        wr_data[1] = bus.hilbert_in;
        nonempty   = '0;
        accept     = '0;
        drop       = '0;
        for (int s = 0; s < 2; s++) begin
            nonempty[s] = (cnt_q[s] != '0);
        end
        pop = &nonempty;
        for (int s = 0; s < 2; s++) begin
            // A full FIFO that pops this cycle still has room for the write.
            accept[s] = wr_req[s] && ((cnt_q[s] != LW'(FIFO_DEPTH)) || pop);
            drop[s]   = wr_req[s] && !accept[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (accept[s]) begin
                    mem_q[s][wr_ptr_q[s]] <= wr_data[s];
                    wr_ptr_q[s]           <= wr_ptr_q[s] + AW'(1);
                end
                if (pop) rd_ptr_q[s] <= rd_ptr_q[s] + AW'(1);
                cnt_q[s] <= cnt_q[s] + LW'(accept[s]) - LW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (!bus.flush) begin
            ovf_q <= ovf_q | drop;
        end
    end

    always_comb begin
        s1_max = (s1_i_q >= s1_q_q) ? s1_i_q : s1_q_q;
        s1_min = (s1_i_q >= s1_q_q) ? s1_q_q : s1_i_q;
        if (MAG_MODE == 0) begin
            comb = {1'b0, s1_i_q} + {1'b0, s1_q_q};
        end else begin
            comb = {1'b0, s1_max} + {3'b000, s1_min[DATA_W-1:2]}
                 + {4'b0000, s1_min[DATA_W-1:3]};
        end
        sat  = (s2_q > SAT_MAX) ? SAT_MAX[DATA_W-1:0] : s2_q[DATA_W-1:0];
        emit = s2_vld_q && (dec_cnt_q == CW'(DECIM - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            mag_valid_q <= 1'b0;
            dec_cnt_q   <= '0;
        end else begin
            s1_vld_q <= pop;
            if (pop) begin
                s1_i_q <= abs_val(mem_q[0][rd_ptr_q[0]]);
                s1_q_q <= abs_val(mem_q[1][rd_ptr_q[1]]);
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) s2_q <= comb;
            mag_valid_q <= emit;
            if (s2_vld_q) dec_cnt_q <= emit ? '0 : dec_cnt_q + CW'(1);
        end
    end

    // Output value holds across flush and across decimated-away samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q <= '0;
        end else if (!bus.flush && emit) begin
            mag_q <= sat;
        end
    end

    assign bus.mag_out   = mag_q;
    assign bus.mag_valid = mag_valid_q;
    assign bus.overflow  = ovf_q;
    assign bus.i_level   = cnt_q[0];
    assign bus.q_level   = cnt_q[1];
endmodule

// File: tb/tb_iq_envelope_detector.sv
// Drives three envelope detector variants (L1, alpha-max-beta-min, decimate-by-4) with
// shared stimulus; a behavioural model feeds per-variant expected-result queues.
module tb_iq_envelope_detector;
    logic        clk = 1'b0;
    logic        rst, flush, real_valid, hilbert_valid;
    logic [15:0] real_in, hilbert_in;
    int          tests_run = 0;
    int          failed = 0;

    logic [15:0] exp0[$], exp1[$], exp4[$];
    int          mi[$], mq[$];
    int          mdec = 0;

    always #5 clk = ~clk;

    iq_envelope_detector_if #(.DATA_W(16), .FIFO_DEPTH(4)) b0 ();
    iq_envelope_detector_if #(.DATA_W(16), .FIFO_DEPTH(4)) b1 ();
    iq_envelope_detector_if #(.DATA_W(16), .FIFO_DEPTH(4)) b4 ();

    assign {b0.real_in, b1.real_in, b4.real_in}                   = {3{real_in}};
    assign {b0.real_valid, b1.real_valid, b4.real_valid}          = {3{real_valid}};
    assign {b0.hilbert_in, b1.hilbert_in, b4.hilbert_in}          = {3{hilbert_in}};
    assign {b0.hilbert_valid, b1.hilbert_valid, b4.hilbert_valid} = {3{hilbert_valid}};
    assign {b0.flush, b1.flush, b4.flush}                         = {3{flush}};

    iq_envelope_detector #(.DATA_W(16), .FIFO_DEPTH(4), .MAG_MODE(0), .DECIM(1)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    iq_envelope_detector #(.DATA_W(16), .FIFO_DEPTH(4), .MAG_MODE(1), .DECIM(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave));
    iq_envelope_detector #(.DATA_W(16), .FIFO_DEPTH(4), .MAG_MODE(0), .DECIM(4)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave));

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int isat(input int x);
        return (x > 32767) ? 32767 : x;
    endfunction

    // Behavioural model: occupancy-driven pairing, pop before push at each edge.
    always @(posedge clk) begin
        int a, b, mx, mn;
        if (rst || flush) begin
            mi.delete(); mq.delete();
            exp0.delete(); exp1.delete(); exp4.delete();
            mdec = 0;
        end else begin
            if (mi.size() > 0 && mq.size() > 0) begin
                a  = iabs(mi.pop_front());
                b  = iabs(mq.pop_front());
                mx = (a >= b) ? a : b;
                mn = (a >= b) ? b : a;
                exp0.push_back(16'(isat(a + b)));
                exp1.push_back(16'(isat(mx + mn / 4 + mn / 8)));
                if (mdec == 3) begin
                    exp4.push_back(16'(isat(a + b)));
                    mdec = 0;
                end else begin
                    mdec++;
                end
            end
            if (real_valid && mi.size() < 4) mi.push_back(int'($signed(real_in)));
            if (hilbert_valid && mq.size() < 4) mq.push_back(int'($signed(hilbert_in)));
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (b0.mag_valid === 1'b1) begin
            tests_run++;
            if (exp0.size() == 0) begin
                failed++;
                $display("FAIL sb_l1 unexpected mag_valid, mag_out=%0d", b0.mag_out);
            end else begin
                e = exp0.pop_front();
                if (b0.mag_out !== e) begin
                    failed++;
                    $display("FAIL sb_l1 mag_out got %0d want %0d", b0.mag_out, e);
                end
            end
        end
        if (b1.mag_valid === 1'b1) begin
            tests_run++;
            if (exp1.size() == 0) begin
                failed++;
                $display("FAIL sb_ambm unexpected mag_valid, mag_out=%0d", b1.mag_out);
            end else begin
                e = exp1.pop_front();
                if (b1.mag_out !== e) begin
                    failed++;
                    $display("FAIL sb_ambm mag_out got %0d want %0d", b1.mag_out, e);
                end
            end
        end
        if (b4.mag_valid === 1'b1) begin
            tests_run++;
            if (exp4.size() == 0) begin
                failed++;
                $display("FAIL sb_decim unexpected mag_valid, mag_out=%0d", b4.mag_out);
            end else begin
                e = exp4.pop_front();
                if (b4.mag_out !== e) begin
                    failed++;
                    $display("FAIL sb_decim mag_out got %0d want %0d", b4.mag_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of stimulus; on return the bench sits in the following cycle.
    task automatic cyc(input bit iv, input int id, input bit qv, input int qd);
        real_valid    = iv;
        real_in       = id[15:0];
        hilbert_valid = qv;
        hilbert_in    = qd[15:0];
        tick();
        real_valid    = 1'b0;
        hilbert_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if (b0.mag_out !== 16'd0 || b0.mag_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_mag got %0d/%0b want 0/0", b0.mag_out, b0.mag_valid);
        end
        tests_run++;
        if (b0.overflow !== 2'b00) begin
            failed++;
            $display("FAIL reset_ovf got %b want 00", b0.overflow);
        end
        tests_run++;
        if (b0.i_level !== 3'd0 || b0.q_level !== 3'd0) begin
            failed++;
            $display("FAIL reset_level got %0d/%0d want 0/0", b0.i_level, b0.q_level);
        end
    endtask

    task automatic test_skew();
        cyc(1, 3000, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, -4000);
        tick();
        tick();
        tests_run++;
        if (b0.mag_valid !== 1'b0) begin
            failed++;
            $display("FAIL skew_early mag_valid got %b want 0", b0.mag_valid);
        end
        tick();
        tests_run++;
        if (b0.mag_valid !== 1'b1 || b0.mag_out !== 16'd7000) begin
            failed++;
            $display("FAIL skew_l1 got %0b/%0d want 1/7000", b0.mag_valid, b0.mag_out);
        end
        tests_run++;
        if (b1.mag_valid !== 1'b1 || b1.mag_out !== 16'd5125) begin
            failed++;
            $display("FAIL skew_ambm got %0b/%0d want 1/5125", b1.mag_valid, b1.mag_out);
        end
        tests_run++;
        if (b0.i_level !== 3'd0 || b0.q_level !== 3'd0) begin
            failed++;
            $display("FAIL skew_level got %0d/%0d want 0/0", b0.i_level, b0.q_level);
        end
        tick();
        tests_run++;
        if (b0.mag_valid !== 1'b0) begin
            failed++;
            $display("FAIL skew_one_shot mag_valid got %b want 0", b0.mag_valid);
        end
    endtask

    task automatic test_multi();
        logic [15:0] want [3];
        want[0] = 16'd101;
        want[1] = 16'd202;
        want[2] = 16'd303;
        cyc(0, 0, 1, 100);
        cyc(0, 0, 1, 200);
        cyc(0, 0, 1, 300);
        tests_run++;
        if (b0.q_level !== 3'd3) begin
            failed++;
            $display("FAIL multi_qlevel got %0d want 3", b0.q_level);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, -1, 0, 0);
        cyc(1, -2, 0, 0);
        cyc(1, -3, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (b0.mag_valid !== 1'b1 || b0.mag_out !== want[k]) begin
                failed++;
                $display("FAIL multi_out%0d got %0b/%0d want 1/%0d", k, b0.mag_valid,
                         b0.mag_out, want[k]);
            end
        end
        tick();
        tests_run++;
        if (b0.mag_valid !== 1'b0) begin
            failed++;
            $display("FAIL multi_tail mag_valid got %b want 0", b0.mag_valid);
        end
    endtask

    task automatic test_sat();
        cyc(1, -32768, 1, -32768);
        tick();
        tick();
        tick();
        tests_run++;
        if (b0.mag_valid !== 1'b1 || b0.mag_out !== 16'd32767) begin
            failed++;
            $display("FAIL sat_l1 got %0b/%0d want 1/32767", b0.mag_valid, b0.mag_out);
        end
        tests_run++;
        if (b1.mag_out !== 16'd32767) begin
            failed++;
            $display("FAIL sat_ambm got %0d want 32767", b1.mag_out);
        end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        for (int k = 0; k < 5; k++) cyc(1, 10 + k, 0, 0);
        tests_run++;
        if (b0.overflow !== 2'b01 || b0.i_level !== 3'd4) begin
            failed++;
            $display("FAIL ovf_set got %b/%0d want 01/4", b0.overflow, b0.i_level);
        end
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, k < 4, k + 1);
            if (b0.mag_valid === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 4) begin
            failed++;
            $display("FAIL ovf_pulses got %0d want 4", pulses);
        end
        tests_run++;
        if (b0.i_level !== 3'd0 || b0.overflow !== 2'b01) begin
            failed++;
            $display("FAIL ovf_after got %0d/%b want 0/01", b0.i_level, b0.overflow);
        end
    endtask

    task automatic test_flush();
        cyc(1, 50, 1, 60);
        cyc(0, 0, 0, 0);
        flush = 1'b1;
        cyc(1, 7, 1, 8);
        flush = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests_run++;
            if (b0.mag_valid !== 1'b0 || b1.mag_valid !== 1'b0) begin
                failed++;
                $display("FAIL flush_kill cycle %0d mag_valid got %b want 0", k, b0.mag_valid);
            end
        end
        tests_run++;
        if (b0.overflow !== 2'b01 || b0.mag_out !== 16'd17) begin
            failed++;
            $display("FAIL flush_hold got %b/%0d want 01/17", b0.overflow, b0.mag_out);
        end
        tests_run++;
        if (b0.i_level !== 3'd0 || b0.q_level !== 3'd0) begin
            failed++;
            $display("FAIL flush_level got %0d/%0d want 0/0", b0.i_level, b0.q_level);
        end
    endtask

    task automatic test_decim();
        bit          want_v;
        logic [15:0] want_m;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 13; c++) begin
            cyc(c < 8, c + 1, c < 8, 0);
            want_v = (c + 1 == 7) || (c + 1 == 11);
            tests_run++;
            if (b4.mag_valid !== want_v) begin
                failed++;
                $display("FAIL decim_valid cycle %0d got %b want %b", c + 1, b4.mag_valid, want_v);
            end
            if (c + 1 >= 7) begin
                want_m = (c + 1 >= 11) ? 16'd8 : 16'd4;
                tests_run++;
                if (b4.mag_out !== want_m) begin
                    failed++;
                    $display("FAIL decim_hold cycle %0d got %0d want %0d", c + 1, b4.mag_out,
                             want_m);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 50, 1, 60);
        cyc(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests_run++;
            if (b0.mag_valid !== 1'b0 || b4.mag_valid !== 1'b0) begin
                failed++;
                $display("FAIL rstmid_kill cycle %0d mag_valid got %b want 0", k, b0.mag_valid);
            end
        end
        tests_run++;
        if (b0.mag_out !== 16'd0 || b0.overflow !== 2'b00) begin
            failed++;
            $display("FAIL rstmid_clear got %0d/%b want 0/00", b0.mag_out, b0.overflow);
        end
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        real_valid = 1'b0;
        hilbert_valid = 1'b0;
        real_in = '0;
        hilbert_in = '0;
        test_reset();
        test_skew();
        test_multi();
        test_sat();
        test_overflow();
        test_flush();
        test_decim();
        test_reset_mid();
        tick();
        tests_run++;
        if (exp0.size() != 0 || exp1.size() != 0 || exp4.size() != 0) begin
            failed++;
            $display("FAIL drain outstanding got %0d/%0d/%0d want 0/0/0", exp0.size(),
                     exp1.size(), exp4.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
